// File: rtl/i2c_apb_regfile_if.sv
// APB3 slave bundle between the fabric and the I2C controller register file.
interface i2c_apb_regfile_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/i2c_apb_regfile.sv
// APB3 register file for the I2C controller: FIFO-guarded data ports, W1C interrupts,
// soft-reset sequencer and timing registers feeding the bit engine.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | no transfer in progress (covers the APB setup cycle)
// ST_ACCESS  | first access cycle: writes complete, reads capture prdata
// ST_RD_WAIT | second access cycle of a read: registered prdata presented
module i2c_apb_regfile #(
  parameter int          FIFO_AW     = 4,
  parameter int          NUM_IRQ     = 8,
  parameter int          TIM_W       = 32,
  parameter int unsigned TIM_RST     = 50,
  parameter int          SRST_CYCLES = 10
) (
  input  logic                   clk,
  input  logic                   rstn,
  i2c_apb_regfile_if.slave       apb,
  output logic                   o_irq,
  input  logic [FIFO_AW:0]       i_tx_fifo_ocy,
  output logic                   o_tx_fifo_wr,
  output logic [9:0]             o_tx_fifo_wdat,
  input  logic [FIFO_AW:0]       i_rx_fifo_ocy,
  output logic                   o_rx_fifo_rd,
  input  logic [7:0]             i_rx_fifo_rdat,
  output logic [FIFO_AW:0]       o_rx_fifo_pirq,
  output logic [9:0]             o_slv_adr,
  output logic                   o_srstn,
  output logic [6:0]             o_cr,
  input  logic [6:0]             i_cr_set,
  input  logic [6:0]             i_cr_clr,
  input  logic [7:0]             i_sr,
  input  logic [NUM_IRQ-1:0]     i_irq_req,
  output logic [8*TIM_W-1:0]     o_tim
);

  localparam int SRST_W = $clog2(SRST_CYCLES + 1);
  localparam logic [FIFO_AW:0] FIFO_FULL = {1'b1, {FIFO_AW{1'b0}}};

  // word addresses (byte address >> 2)
  localparam logic [9:0] W_GIE   = 10'h007;
  localparam logic [9:0] W_ISR   = 10'h008;
  localparam logic [9:0] W_IER   = 10'h00A;
  localparam logic [9:0] W_SRST  = 10'h010;
  localparam logic [9:0] W_CR    = 10'h040;
  localparam logic [9:0] W_SR    = 10'h041;
  localparam logic [9:0] W_TXR   = 10'h042;
  localparam logic [9:0] W_RXD   = 10'h043;
  localparam logic [9:0] W_ADR   = 10'h044;
  localparam logic [9:0] W_TXOCY = 10'h045;
  localparam logic [9:0] W_RXOCY = 10'h046;
  localparam logic [9:0] W_TEN   = 10'h047;
  localparam logic [9:0] W_PIRQ  = 10'h048;
  localparam logic [9:0] W_TIM0  = 10'h04A;
  localparam logic [9:0] W_TIM7  = 10'h051;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RD_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_gie;
  logic [NUM_IRQ-1:0]  r_isr;
  logic [NUM_IRQ-1:0]  r_ier;
  logic [6:0]          r_cr;
  logic [9:0]          r_txr;
  logic [6:0]          r_adr;
  logic [2:0]          r_ten_adr;
  logic [FIFO_AW:0]    r_rx_pirq;
  logic [TIM_W-1:0]    r_tim [8];
  logic [SRST_W-1:0]   r_srst_cnt;
  logic [31:0]         r_prdata;
  logic                r_rd_err;

  logic [9:0]          w_word;
  logic                w_tim_hit;
  logic [2:0]          w_tim_idx;
  logic                w_tx_full;
  logic                w_rx_empty;
  logic [31:0]         w_rdata;
  logic                w_rd_err;
  logic                w_wr_err;
  logic                w_ro;
  logic                w_mapped;
  logic                w_acc;
  logic                w_wr_en;
  logic                w_rd_first;
  logic                w_key;
  logic [NUM_IRQ-1:0]  w_w1c;
  logic                w_pready;
  logic                w_pslverr;

  assign w_word     = apb.paddr[11:2];
  assign w_tim_hit  = (w_word >= W_TIM0) && (w_word <= W_TIM7);
  // W_TIM0 has [2:0]=3'b010, so the slot index wraps modulo 8
  assign w_tim_idx  = w_word[2:0] - 3'd2;
  assign w_tx_full  = (i_tx_fifo_ocy == FIFO_FULL);
  assign w_rx_empty = (i_rx_fifo_ocy == '0);

  always_comb begin
    w_rdata  = '0;
    w_rd_err = 1'b0;
    w_wr_err = 1'b0;
    w_ro     = 1'b0;
    w_mapped = 1'b1;
    case (w_word)
      W_GIE:   w_rdata = {r_gie, 31'b0};
      W_ISR:   w_rdata = 32'(r_isr);
      W_IER:   w_rdata = 32'(r_ier);
      W_SRST:  w_rd_err = 1'b1;
      W_CR:    w_rdata = {25'b0, r_cr};
      W_SR: begin
        w_rdata = {24'b0, i_sr};
        w_ro    = 1'b1;
      end
      W_TXR: begin
        w_rdata  = {22'b0, r_txr};
        w_wr_err = w_tx_full;
      end
      W_RXD: begin
        w_ro     = 1'b1;
        w_rd_err = w_rx_empty;
        w_rdata  = {24'b0, i_rx_fifo_rdat};
      end
      W_ADR:   w_rdata = {24'b0, r_adr, 1'b0};
      W_TXOCY: begin
        w_rdata = 32'(i_tx_fifo_ocy);
        w_ro    = 1'b1;
      end
      W_RXOCY: begin
        w_rdata = 32'(i_rx_fifo_ocy);
        w_ro    = 1'b1;
      end
      W_TEN:   w_rdata = {29'b0, r_ten_adr};
      W_PIRQ:  w_rdata = 32'(r_rx_pirq);
      default: begin
        if (w_tim_hit) w_rdata = 32'(r_tim[w_tim_idx]);
        else           w_mapped = 1'b0;
      end
    endcase
    if (!w_mapped) begin
      w_rd_err = 1'b1;
      w_wr_err = 1'b1;
    end
    if (w_ro)     w_wr_err = 1'b1;
    if (w_rd_err) w_rdata  = '0;
  end

  assign w_acc      = (r_state == ST_ACCESS) && apb.psel && apb.penable;
  assign w_wr_en    = w_acc && apb.pwrite && !w_wr_err;
  assign w_rd_first = w_acc && !apb.pwrite;
  assign w_key      = w_wr_en && (w_word == W_SRST) && (apb.pwdata == 32'h0000_000A);
  assign w_w1c      = (w_wr_en && (w_word == W_ISR)) ? apb.pwdata[NUM_IRQ-1:0] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_pready  = 1'b1;
    w_pslverr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (apb.psel && !apb.penable) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!(apb.psel && apb.penable)) begin
          w_next = ST_IDLE;
        end else if (apb.pwrite) begin
          w_pslverr = w_wr_err;
          w_next    = ST_IDLE;
        end else begin
          w_pready = 1'b0;
          w_next   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        w_pslverr = r_rd_err;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prdata <= '0;
      r_rd_err <= 1'b0;
    end else if (w_rd_first) begin
      r_prdata <= w_rdata;
      r_rd_err <= w_rd_err;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gie     <= 1'b0;
      r_ier     <= '0;
      r_adr     <= '0;
      r_ten_adr <= '0;
      r_rx_pirq <= (FIFO_AW+1)'(1);
      for (int i = 0; i < 8; i++) r_tim[i] <= TIM_W'(TIM_RST);
    end else if (w_wr_en) begin
      case (w_word)
        W_GIE:  r_gie     <= apb.pwdata[31];
        W_IER:  r_ier     <= apb.pwdata[NUM_IRQ-1:0];
        W_ADR:  r_adr     <= apb.pwdata[7:1];
        W_TEN:  r_ten_adr <= apb.pwdata[2:0];
        W_PIRQ: r_rx_pirq <= apb.pwdata[FIFO_AW:0];
        default: begin
          if (w_tim_hit) r_tim[w_tim_idx] <= TIM_W'(apb.pwdata);
        end
      endcase
    end
  end

  // registers owned jointly by the bus and the core; the soft-reset key clears them
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cr  <= '0;
      r_isr <= '0;
      r_txr <= '0;
    end else if (w_key) begin
      r_cr  <= '0;
      r_isr <= '0;
      r_txr <= '0;
    end else begin
      if (w_wr_en && (w_word == W_CR)) r_cr <= apb.pwdata[6:0];
      else                             r_cr <= (r_cr | i_cr_set) & ~i_cr_clr;
      r_isr <= (r_isr & ~w_w1c) | i_irq_req;
      if (o_tx_fifo_wr) r_txr <= apb.pwdata[9:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 r_srst_cnt <= '0;
    else if (w_key)            r_srst_cnt <= SRST_W'(SRST_CYCLES);
    else if (r_srst_cnt != '0) r_srst_cnt <= r_srst_cnt - 1'b1;
  end

  assign o_tx_fifo_wr   = w_wr_en && (w_word == W_TXR);
  assign o_tx_fifo_wdat = o_tx_fifo_wr ? apb.pwdata[9:0] : r_txr;
  assign o_rx_fifo_rd   = w_rd_first && !w_rd_err && (w_word == W_RXD);
  assign o_rx_fifo_pirq = r_rx_pirq;
  assign o_slv_adr      = {r_ten_adr, r_adr};
  assign o_srstn        = (r_srst_cnt == '0);
  assign o_cr           = r_cr;
  assign o_irq          = r_gie && |(r_isr & r_ier);

  for (genvar g = 0; g < 8; g++) begin : g_tim
    assign o_tim[g*TIM_W +: TIM_W] = r_tim[g];
  end

  assign apb.prdata  = r_prdata;
  assign apb.pready  = w_pready;
  assign apb.pslverr = w_pslverr;

endmodule

// File: tb/tb_i2c_apb_regfile.sv
// Directed bench for i2c_apb_regfile: APB responses go through an expected-response
// queue checked by a monitor; sideband outputs are checked inline.
module tb_i2c_apb_regfile;
  localparam int FIFO_AW = 4;
  localparam int NUM_IRQ = 8;
  localparam int TIM_W   = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  i2c_apb_regfile_if apb ();

  logic [FIFO_AW:0]   tx_ocy, rx_ocy, rx_pirq;
  logic               irq, tx_wr, rx_rd, srstn;
  logic [9:0]         tx_wdat, slv_adr;
  logic [7:0]         rx_rdat, sr;
  logic [6:0]         cr_o, cr_set, cr_clr;
  logic [NUM_IRQ-1:0] irq_req;
  logic [8*TIM_W-1:0] tim;

  i2c_apb_regfile #(
    .FIFO_AW(FIFO_AW), .NUM_IRQ(NUM_IRQ), .TIM_W(TIM_W), .TIM_RST(50), .SRST_CYCLES(10)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .apb            (apb),
    .o_irq          (irq),
    .i_tx_fifo_ocy  (tx_ocy),
    .o_tx_fifo_wr   (tx_wr),
    .o_tx_fifo_wdat (tx_wdat),
    .i_rx_fifo_ocy  (rx_ocy),
    .o_rx_fifo_rd   (rx_rd),
    .i_rx_fifo_rdat (rx_rdat),
    .o_rx_fifo_pirq (rx_pirq),
    .o_slv_adr      (slv_adr),
    .o_srstn        (srstn),
    .o_cr           (cr_o),
    .i_cr_set       (cr_set),
    .i_cr_clr       (cr_clr),
    .i_sr           (sr),
    .i_irq_req      (irq_req),
    .o_tim          (tim)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        err;
    logic        chk_d;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    n_push = 0;
  int    n_pop = 0;
  int    n_srstn_hi = 0;
  logic [9:0] last_wdat = '0;

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (tx_wr) begin
          n_push++;
          last_wdat = tx_wdat;
        end
        if (rx_rd) n_pop++;
        if (srstn) n_srstn_hi++;
        if (apb.psel && apb.penable && apb.pready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: response at addr %h with no expected entry", apb.paddr);
          end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (apb.pslverr !== e.err) begin
              n_fail++;
              $display("FAIL %s pslverr: got %0b expected %0b", nm, apb.pslverr, e.err);
            end
            if (e.chk_d) begin
              n_checks++;
              if (apb.prdata !== e.d) begin
                n_fail++;
                $display("FAIL %s prdata: got %h expected %h", nm, apb.prdata, e.d);
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                          input logic [31:0] ed, input logic ee, input string nm,
                          input logic [NUM_IRQ-1:0] irq_acc, input logic [6:0] clr_acc,
                          output int acc);
    int cyc;
    exp_q.push_back('{d: ed, err: ee, chk_d: !wr});
    name_q.push_back(nm);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = a; apb.pwdata = d;
    @(posedge clk); #1;
    apb.penable = 1'b1; irq_req = irq_acc; cr_clr = clr_acc;
    cyc = 1;
    forever begin
      @(negedge clk);
      if (apb.pready) break;
      cyc++;
      if (cyc > 16) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s timeout: pready low for %0d cycles, required at most 2", nm, cyc);
        break;
      end
    end
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; irq_req = '0; cr_clr = '0;
    acc = cyc;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic ee, input string nm);
    int acc;
    apb_xfer(1'b1, a, d, 32'h0, ee, nm, '0, '0, acc);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] ed, input logic ee, input string nm);
    int acc;
    apb_xfer(1'b0, a, 32'h0, ed, ee, nm, '0, '0, acc);
  endtask

  initial begin : stim
    int acc;
    int low;
    int hi0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    tx_ocy = '0; rx_ocy = '0; rx_rdat = '0; sr = 8'h5A;
    cr_set = '0; cr_clr = '0; irq_req = '0;

    @(negedge clk);
    chk("rst_pready", apb.pready, 1);
    chk("rst_pslverr", apb.pslverr, 0);
    chk("rst_prdata", apb.prdata, 0);
    chk("rst_srstn", srstn, 1);
    chk("rst_irq", irq, 0);
    chk("rst_cr", cr_o, 0);
    chk("rst_slv_adr", slv_adr, 0);
    chk("rst_rx_pirq", rx_pirq, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_tim%0d", i), tim[i*32 +: 32], 50);
    @(posedge clk); #1;
    rstn = 1'b1;

    apb_xfer(1'b0, 12'h128, 32'h0, 32'd50, 1'b0, "rd_tim0", '0, '0, acc);
    chk("rd_access_cycles", acc, 2);
    apb_xfer(1'b1, 12'h12C, 32'h1234, 32'h0, 1'b0, "wr_tim1", '0, '0, acc);
    chk("wr_access_cycles", acc, 1);
    chk("tim1_out", tim[63:32], 32'h1234);
    rd(12'h12C, 32'h1234, 1'b0, "rd_tim1");
    wr(12'h144, 32'hBEEF, 1'b0, "wr_tim7");
    chk("tim7_out", tim[255:224], 32'hBEEF);
    rd(12'h148, 32'h0, 1'b1, "rd_past_tim");
    rd(12'h200, 32'h0, 1'b1, "rd_unmapped");
    wr(12'h104, 32'hFF, 1'b1, "wr_ro_sr");
    rd(12'h104, 32'h5A, 1'b0, "rd_sr");
    rd(12'h040, 32'h0, 1'b1, "rd_srst");

    tx_ocy = 5'd5;
    wr(12'h108, 32'h2AB, 1'b0, "wr_txr");
    chk("tx_push_one", n_push, 1);
    chk("tx_wdat", last_wdat, 10'h2AB);
    tx_ocy = 5'd16;
    wr(12'h108, 32'h155, 1'b1, "wr_txr_full");
    chk("tx_full_no_push", n_push, 1);
    rd(12'h108, 32'h2AB, 1'b0, "rd_txr");
    rd(12'h114, 32'd16, 1'b0, "rd_tx_ocy");

    rx_ocy = '0;
    rd(12'h10C, 32'h0, 1'b1, "rd_rx_empty");
    chk("rx_empty_no_pop", n_pop, 0);
    rx_ocy = 5'd1; rx_rdat = 8'hA5;
    rd(12'h10C, 32'hA5, 1'b0, "rd_rx");
    chk("rx_one_pop", n_pop, 1);
    rd(12'h118, 32'd1, 1'b0, "rd_rx_ocy");

    wr(12'h110, 32'h54, 1'b0, "wr_adr");
    wr(12'h11C, 32'h5, 1'b0, "wr_ten_adr");
    chk("slv_adr", slv_adr, 10'h2AA);
    rd(12'h110, 32'h54, 1'b0, "rd_adr");
    wr(12'h120, 32'h7, 1'b0, "wr_pirq");
    chk("rx_pirq_out", rx_pirq, 7);

    @(posedge clk); #1; irq_req = 8'h08;
    @(posedge clk); #1; irq_req = 8'h00;
    wr(12'h028, 32'h08, 1'b0, "wr_ier");
    chk("irq_gie_off", irq, 0);
    wr(12'h01C, 32'h8000_0000, 1'b0, "wr_gie");
    @(negedge clk);
    chk("irq_on", irq, 1);
    rd(12'h01C, 32'h8000_0000, 1'b0, "rd_gie");
    apb_xfer(1'b1, 12'h020, 32'h08, 32'h0, 1'b0, "w1c_vs_set", 8'h08, '0, acc);
    rd(12'h020, 32'h08, 1'b0, "rd_isr_set_wins");
    wr(12'h020, 32'h08, 1'b0, "w1c_isr");
    rd(12'h020, 32'h00, 1'b0, "rd_isr_cleared");
    chk("irq_off", irq, 0);

    @(posedge clk); #1; cr_set = 7'h01; cr_clr = 7'h01;
    @(posedge clk); #1; cr_set = 7'h00; cr_clr = 7'h00;
    @(negedge clk); chk("cr_clr_wins", cr_o, 0);
    @(posedge clk); #1; cr_set = 7'h06;
    @(posedge clk); #1; cr_set = 7'h00;
    @(negedge clk); chk("cr_set", cr_o, 7'h06);
    apb_xfer(1'b1, 12'h100, 32'h7F, 32'h0, 1'b0, "wr_cr_vs_clr", '0, 7'h7F, acc);
    @(negedge clk); chk("cr_apb_wins", cr_o, 7'h7F);
    rd(12'h100, 32'h7F, 1'b0, "rd_cr");

    @(posedge clk); #1; irq_req = 8'h02;
    @(posedge clk); #1; irq_req = 8'h00;
    wr(12'h040, 32'hA, 1'b0, "wr_srst_key");
    @(negedge clk);
    chk("srst_cr_cleared", cr_o, 0);
    chk("srstn_low_first", srstn, 0);
    low = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (srstn) break;
      low++;
    end
    chk("srst_low_cycles", low, 10);
    rd(12'h020, 32'h0, 1'b0, "rd_isr_after_srst");
    rd(12'h028, 32'h08, 1'b0, "rd_ier_kept");
    rd(12'h110, 32'h54, 1'b0, "rd_adr_kept");
    rd(12'h108, 32'h0, 1'b0, "rd_txr_after_srst");

    wr(12'h040, 32'hA, 1'b0, "wr_srst_key1");
    hi0 = n_srstn_hi;
    repeat (4) @(posedge clk);
    wr(12'h040, 32'hA, 1'b0, "wr_srst_key2");
    chk("srst_no_gap", n_srstn_hi - hi0, 0);
    low = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (srstn) break;
      low++;
    end
    chk("srst_reload_cycles", low, 10);
    wr(12'h040, 32'h5, 1'b0, "wr_srst_other");
    repeat (3) @(negedge clk);
    chk("srst_other_ignored", srstn, 1);

    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 12'h12C;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(negedge clk);
    chk("abort_wait_state", apb.pready, 0);
    #2 rstn = 1'b0;
    @(negedge clk);
    chk("abort_pready", apb.pready, 1);
    chk("abort_prdata", apb.prdata, 0);
    chk("abort_tim1", tim[63:32], 50);
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    rd(12'h12C, 32'd50, 1'b0, "rd_after_abort");

    repeat (2) @(negedge clk);
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
